risc8_intr_ctrl: RTL and testbench

Interrupt controller for the 8-bit RISC core. It latches rising edges from up to eight peripheral interrupt lines and applies a software mask and a global enable. It selects the highest-priority pending source and drives the datapath's `interrupt` input with a one-cycle pulse, while placing a one-hot source flag on the COM read bus for the datapath to latch. It then blocks further dispatch until the core signals return-from-interrupt, and exposes its registers on the COM bus.

---
 rtl/risc8_intr_ctrl_if.sv | 21 ++
 rtl/risc8_intr_ctrl.sv | 111 +++++++++++
 tb/tb_risc8_intr_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/risc8_intr_ctrl_if.sv
// rtl/risc8_intr_ctrl_if.sv - COM bus and dispatch handshake between datapath and interrupt controller
interface risc8_intr_ctrl_if;
   logic [7:0] com_addr;
   logic [7:0] com_wr;
   logic       com_we;
   logic [7:0] com_rd;
   logic       hold;
   logic       intr_ret;
   logic       interrupt;
   logic       in_service;

   modport master (
      output com_addr, com_wr, com_we, hold, intr_ret,
      input  com_rd, interrupt, in_service
   );

   modport slave (
      input  com_addr, com_wr, com_we, hold, intr_ret,
      output com_rd, interrupt, in_service
   );
endinterface

// File: rtl/risc8_intr_ctrl.sv
// rtl/risc8_intr_ctrl.sv - edge-latched, priority-encoded interrupt controller for the 8-bit RISC core
module risc8_intr_ctrl #(
   parameter int         NSRC      = 8,
   parameter logic [7:0] BASE_ADDR = 8'h10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_in,
   risc8_intr_ctrl_if.slave bus
);

   // Bits at or above NSRC never exist, so they are forced to zero everywhere
   localparam logic [7:0] SRC_MASK  = 8'(~(16'hFFFF << NSRC));
   localparam logic [7:0] ADDR_MASK = BASE_ADDR;
   localparam logic [7:0] ADDR_PEND = BASE_ADDR + 8'd1;
   localparam logic [7:0] ADDR_CTRL = BASE_ADDR + 8'd2;
   localparam logic [7:0] ADDR_STAT = BASE_ADDR + 8'd3;

   typedef enum logic [1:0] {IDLE, FIRE, SERVICE} state_t;

   state_t     state, state_next;
   logic [7:0] irq_now, irq_prev, rise;
   logic [7:0] mask, pend, pend_next, elig;
   logic       gie;
   logic [2:0] last_id, grant_id;
   logic       dispatch;
   logic       wr_mask, wr_pend, wr_ctrl;

   assign irq_now = 8'(irq_in);
   assign rise    = irq_now & ~irq_prev;
   assign elig    = pend & mask;
   assign wr_mask = bus.com_we && (bus.com_addr == ADDR_MASK);
   assign wr_pend = bus.com_we && (bus.com_addr == ADDR_PEND);
   assign wr_ctrl = bus.com_we && (bus.com_addr == ADDR_CTRL);

   assign bus.interrupt  = (state == FIRE);
   assign bus.in_service = (state != IDLE);

   // Lowest set eligible index wins: scan downward so the last hit is the lowest
   always_comb begin
      grant_id = '0;
      for (int i = 7; i >= 0; i--) begin
         if (elig[i]) grant_id = 3'(i);
      end
   end

   // Next-state logic; dispatch marks the IDLE->FIRE transition
   always_comb begin
      state_next = state;
      dispatch   = 1'b0;
      case (state)
         IDLE: begin
            if (gie && (elig != 8'h00) && !bus.hold) begin
               state_next = FIRE;
               dispatch   = 1'b1;
            end
         end
         FIRE:    state_next = SERVICE;
         SERVICE: if (bus.intr_ret) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pending update: clears (software and grant) first, new edges last so a set wins
   always_comb begin
      pend_next = pend;
      if (wr_pend) pend_next = pend_next & ~bus.com_wr;
      if (dispatch) pend_next[grant_id] = 1'b0;
      pend_next = (pend_next | rise) & SRC_MASK;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Edge history, software registers and the dispatched id
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_prev <= 8'hFF;
         mask     <= 8'h00;
         pend     <= 8'h00;
         gie      <= 1'b0;
         last_id  <= 3'd0;
      end else begin
         irq_prev <= irq_now;
         pend     <= pend_next;
         if (wr_mask)  mask    <= bus.com_wr & SRC_MASK;
         if (wr_ctrl)  gie     <= bus.com_wr[0];
         if (dispatch) last_id <= grant_id;
      end
   end

   // COM read: the one-hot source flag overrides the decode during FIRE
   always_comb begin
      bus.com_rd = 8'h00;
      if (state == FIRE) begin
         bus.com_rd = 8'd1 << last_id;
      end else begin
         case (bus.com_addr)
            ADDR_MASK: bus.com_rd = mask;
            ADDR_PEND: bus.com_rd = pend;
            ADDR_CTRL: bus.com_rd = {7'd0, gie};
            ADDR_STAT: bus.com_rd = {bus.in_service, 4'd0, last_id};
            default:   bus.com_rd = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_risc8_intr_ctrl.sv
// tb/tb_risc8_intr_ctrl.sv - self-checking bench for risc8_intr_ctrl
module tb_risc8_intr_ctrl;

   localparam logic [7:0] A_MASK = 8'h10;
   localparam logic [7:0] A_PEND = 8'h11;
   localparam logic [7:0] A_CTRL = 8'h12;
   localparam logic [7:0] A_STAT = 8'h13;

   typedef struct {
      logic [7:0] addr;
      logic       we;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_in;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_fire = -100;
   logic [7:0] exp_q[$];
   vec_t       tbl[17];

   risc8_intr_ctrl_if bus();

   risc8_intr_ctrl #(.NSRC(8), .BASE_ADDR(8'h10)) dut (
      .clk    (clk),
      .rst    (rst),
      .irq_in (irq_in),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%02h exp=%02h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic com_write(input logic [7:0] a, input logic [7:0] d);
      bus.com_addr = a;
      bus.com_wr   = d;
      bus.com_we   = 1'b1;
      tick();
      bus.com_we   = 1'b0;
   endtask

   task automatic com_read(input logic [7:0] a, input logic [7:0] exp, input string name);
      bus.com_addr = a;
      #1;
      check(name, bus.com_rd, exp);
   endtask

   task automatic ret_pulse();
      bus.intr_ret = 1'b1;
      tick();
      bus.intr_ret = 1'b0;
   endtask

   // Scoreboard: every dispatch pulse must match the next queued flag and keep spacing
   always @(negedge clk) begin
      if (bus.interrupt) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_interrupt got_flag=%02h exp=none", bus.com_rd);
         end else begin
            check("flag", bus.com_rd, exp_q.pop_front());
            checks++;
            if (cyc - last_fire < 3) begin
               errors++;
               $display("FAIL pulse_spacing got=%0d exp>=3", cyc - last_fire);
            end
         end
         last_fire = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{A_MASK, 1'b0, 8'h00, 8'h00};
      tbl[1]  = '{A_PEND, 1'b0, 8'h00, 8'h00};
      tbl[2]  = '{A_CTRL, 1'b0, 8'h00, 8'h00};
      tbl[3]  = '{A_STAT, 1'b0, 8'h00, 8'h00};
      tbl[4]  = '{A_MASK, 1'b1, 8'hA5, 8'h00};
      tbl[5]  = '{A_MASK, 1'b0, 8'h00, 8'hA5};
      tbl[6]  = '{A_CTRL, 1'b1, 8'hFF, 8'h00};
      tbl[7]  = '{A_CTRL, 1'b0, 8'h00, 8'h01};
      tbl[8]  = '{8'h14,  1'b1, 8'hFF, 8'h00};
      tbl[9]  = '{8'h14,  1'b0, 8'h00, 8'h00};
      tbl[10] = '{A_STAT, 1'b1, 8'hFF, 8'h00};
      tbl[11] = '{A_STAT, 1'b0, 8'h00, 8'h00};
      tbl[12] = '{A_PEND, 1'b1, 8'hFF, 8'h00};
      tbl[13] = '{A_PEND, 1'b0, 8'h00, 8'h00};
      tbl[14] = '{A_MASK, 1'b1, 8'h00, 8'h00};
      tbl[15] = '{A_CTRL, 1'b1, 8'h00, 8'h00};
      tbl[16] = '{A_MASK, 1'b0, 8'h00, 8'h00};

      rst = 1'b1;
      irq_in = 8'h00;
      bus.com_addr = 8'h00;
      bus.com_wr = 8'h00;
      bus.com_we = 1'b0;
      bus.hold = 1'b0;
      bus.intr_ret = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_interrupt", {7'd0, bus.interrupt}, 8'h00);
      check("reset_in_service", {7'd0, bus.in_service}, 8'h00);

      // Register access vectors
      for (int i = 0; i < 17; i++) begin
         if (tbl[i].we) com_write(tbl[i].addr, tbl[i].data);
         else com_read(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d", i));
      end

      // Basic dispatch
      com_write(A_MASK, 8'h04);
      com_write(A_CTRL, 8'h01);
      exp_q.push_back(8'h04);
      irq_in = 8'h04;
      tick();
      irq_in = 8'h00;
      check("basic_no_early_irq", {7'd0, bus.interrupt}, 8'h00);
      tick();
      check("basic_interrupt", {7'd0, bus.interrupt}, 8'h01);
      check("basic_flag", bus.com_rd, 8'h04);
      tick();
      check("basic_pulse_end", {7'd0, bus.interrupt}, 8'h00);
      com_read(A_PEND, 8'h00, "basic_pend");
      com_read(A_STAT, 8'h82, "basic_stat");
      ret_pulse();
      check("basic_returned", {7'd0, bus.in_service}, 8'h00);

      // Priority: sources 1 and 5 together
      com_write(A_MASK, 8'hFF);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h20);
      irq_in = 8'h22;
      tick();
      irq_in = 8'h00;
      tick();
      check("prio_first", {7'd0, bus.interrupt}, 8'h01);
      tick();
      com_read(A_PEND, 8'h20, "prio_pend");
      ret_pulse();
      check("prio_gap", {7'd0, bus.interrupt}, 8'h00);
      tick();
      check("prio_second", {7'd0, bus.interrupt}, 8'h01);
      tick();
      ret_pulse();

      // Masked edge latches without dispatch, then software clear
      com_write(A_MASK, 8'h00);
      irq_in = 8'h08;
      tick();
      irq_in = 8'h00;
      repeat (3) tick();
      com_read(A_PEND, 8'h08, "mask_pend_latched");
      check("mask_no_service", {7'd0, bus.in_service}, 8'h00);
      com_write(A_PEND, 8'h08);
      com_read(A_PEND, 8'h00, "mask_pend_cleared");
      com_write(A_MASK, 8'h08);
      repeat (3) tick();
      check("mask_no_dispatch", {7'd0, bus.in_service}, 8'h00);

      // Same-cycle clear and new edge: the set wins
      exp_q.push_back(8'h08);
      bus.com_addr = A_PEND;
      bus.com_wr = 8'h08;
      bus.com_we = 1'b1;
      irq_in = 8'h08;
      tick();
      bus.com_we = 1'b0;
      irq_in = 8'h00;
      com_read(A_PEND, 8'h08, "same_cycle_pend");
      tick();
      check("same_cycle_dispatch", {7'd0, bus.interrupt}, 8'h01);
      tick();
      ret_pulse();

      // Hold postpones dispatch; an edge during service waits in PEND
      com_write(A_MASK, 8'h01);
      bus.hold = 1'b1;
      irq_in = 8'h01;
      tick();
      irq_in = 8'h00;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("hold_block%0d", i), {7'd0, bus.in_service}, 8'h00);
      end
      exp_q.push_back(8'h01);
      bus.hold = 1'b0;
      tick();
      check("hold_release_dispatch", {7'd0, bus.interrupt}, 8'h01);
      tick();
      irq_in = 8'h01;
      tick();
      irq_in = 8'h00;
      tick();
      com_read(A_PEND, 8'h01, "nest_pend");
      check("nest_still_service", {7'd0, bus.in_service}, 8'h01);
      exp_q.push_back(8'h01);
      ret_pulse();
      tick();
      check("nest_second_dispatch", {7'd0, bus.interrupt}, 8'h01);
      tick();
      com_read(A_PEND, 8'h00, "nest_pend_clear");

      // Reset while in service with every line held high
      irq_in = 8'hFF;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_interrupt", {7'd0, bus.interrupt}, 8'h00);
      check("rst_in_service", {7'd0, bus.in_service}, 8'h00);
      com_read(A_MASK, 8'h00, "rst_mask");
      com_read(A_PEND, 8'h00, "rst_pend");
      com_read(A_CTRL, 8'h00, "rst_ctrl");
      repeat (3) tick();
      com_read(A_PEND, 8'h00, "rst_no_spurious_edge");
      irq_in = 8'h00;
      tick();

      check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
